inst_fetch: RTL and testbench

- Instruction fetch stage; owns the architectural program counter and fetches instructions from instruction memory over a valid/ready request port plus an in-order response port.
- Buffers fetched instructions with their PCs in a 2-entry FIFO toward decode.
- Accepts branch/jump redirects from execute; flushes buffered and in-flight instructions on redirect.

---
 rtl/inst_fetch_if.sv | 34 +++
 rtl/inst_fetch.sv | 127 ++++++++++++
 tb/tb_inst_fetch.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: execute redirect, instruction-memory request/response and decode-side FIFO head.
// master is the fetch unit; slave is the environment (execute, memory, decode).
interface inst_fetch_if #(
   parameter int XLEN   = 32,
   parameter int INST_W = 32
);
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              imem_req_valid;
   logic [XLEN-1:0]   imem_req_addr;
   logic              imem_req_ready;
   logic              imem_resp_valid;
   logic [INST_W-1:0] imem_resp_data;
   logic              inst_valid;
   logic [XLEN-1:0]   inst_pc;
   logic [INST_W-1:0] inst_data;
   logic              inst_ready;

   modport master (
      input  redirect_valid, redirect_pc,
      input  imem_req_ready, imem_resp_valid, imem_resp_data,
      input  inst_ready,
      output imem_req_valid, imem_req_addr,
      output inst_valid, inst_pc, inst_data
   );

   modport slave (
      output redirect_valid, redirect_pc,
      output imem_req_ready, imem_resp_valid, imem_resp_data,
      output inst_ready,
      input  imem_req_valid, imem_req_addr,
      input  inst_valid, inst_pc, inst_data
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, issues credit-limited memory requests, buffers {pc, inst}
// in a 2-entry FIFO with a registered head, and flushes on execute redirects.
module inst_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              INST_W   = 32
) (
   input  logic         clk,
   input  logic         rst,
   inst_fetch_if.master bus
);

   typedef struct packed {
      logic [XLEN-1:0]   pc;
      logic [INST_W-1:0] data;
   } entry_t;

   logic [XLEN-1:0] fetch_pc;
   logic [1:0]      outstanding;
   logic [1:0]      drop_cnt;
   logic [XLEN-1:0] pcq [2];
   logic            pcq_wr;
   logic            pcq_rd;
   logic            head_valid;
   logic            tail_valid;
   entry_t          head;
   entry_t          tail;

   logic       redirect;
   logic       req_fire;
   logic       resp;
   logic       resp_keep;
   logic       pop;
   logic [2:0] credit_used;
   entry_t     new_entry;

   assign redirect    = bus.redirect_valid;
   assign resp        = bus.imem_resp_valid;
   assign credit_used = {1'b0, outstanding} + {2'b00, head_valid} + {2'b00, tail_valid};

   // Every accepted request is guaranteed a FIFO slot, so the response port never stalls.
   assign bus.imem_req_valid = rst && !redirect && (drop_cnt == 2'd0) && (credit_used < 3'd2);
   assign bus.imem_req_addr  = fetch_pc;

   assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
   assign resp_keep = resp && (drop_cnt == 2'd0) && !redirect;
   assign pop       = head_valid && bus.inst_ready && !redirect;
   assign new_entry = '{pc: pcq[pcq_rd], data: bus.imem_resp_data};

   assign bus.inst_valid = head_valid;
   assign bus.inst_pc    = head.pc;
   assign bus.inst_data  = head.data;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc    <= RESET_PC;
         outstanding <= 2'd0;
         drop_cnt    <= 2'd0;
         pcq_wr      <= 1'b0;
         pcq_rd      <= 1'b0;
      end else begin
         outstanding <= outstanding + {1'b0, req_fire} - {1'b0, resp};
         if (redirect) begin
            // In-flight requests still come back; count them so their data is discarded.
            fetch_pc <= bus.redirect_pc;
            drop_cnt <= outstanding - {1'b0, resp};
            pcq_wr   <= 1'b0;
            pcq_rd   <= 1'b0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + XLEN'(4);
               pcq_wr   <= ~pcq_wr;
            end
            if (resp && (drop_cnt != 2'd0)) drop_cnt <= drop_cnt - 2'd1;
            if (resp_keep) pcq_rd <= ~pcq_rd;
         end
      end
   end

   // NOTE: the PC queue storage has no reset; its read/write pointers alone define emptiness.
   always_ff @(posedge clk) begin
      if (req_fire) pcq[pcq_wr] <= fetch_pc;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_valid <= 1'b0;
         tail_valid <= 1'b0;
         head       <= '0;
         tail       <= '0;
      end else if (redirect) begin
         head_valid <= 1'b0;
         tail_valid <= 1'b0;
      end else begin
         case ({pop, resp_keep})
            2'b11: begin
               if (tail_valid) begin
                  head <= tail;
                  tail <= new_entry;
               end else begin
                  head <= new_entry;
               end
            end
            2'b10: begin
               if (tail_valid) begin
                  head       <= tail;
                  tail_valid <= 1'b0;
               end else begin
                  head_valid <= 1'b0;
               end
            end
            2'b01: begin
               if (head_valid) begin
                  tail       <= new_entry;
                  tail_valid <= 1'b1;
               end else begin
                  head       <= new_entry;
                  head_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: an in-order memory with random latency feeds the DUT while a
// queue-based model of the fetch rules predicts every output each cycle.
module tb_inst_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          NCYC     = 3000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   inst_fetch_if #(.XLEN(32), .INST_W(32)) bus ();

   inst_fetch #(.XLEN(32), .RESET_PC(RESET_PC), .INST_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } inst_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   // Reference model state: buffered instructions, PCs awaiting data, credit and drop counts.
   inst_t       m_fifo[$];
   logic [31:0] m_inflight[$];
   int          m_out;
   int          m_drop;
   logic [31:0] m_pc;
   inst_t       m_shown;
   mreq_t       mem_q[$];

   task automatic model_reset();
      m_fifo.delete();
      m_inflight.delete();
      mem_q.delete();
      m_out   = 0;
      m_drop  = 0;
      m_pc    = RESET_PC;
      m_shown = '{pc: 32'h0, data: 32'h0};
   endtask

   task automatic drive_idle();
      bus.redirect_valid  = 1'b0;
      bus.redirect_pc     = 32'h0;
      bus.imem_req_ready  = 1'b0;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'h0;
      bus.inst_ready      = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst = 1'b0;
      #1;
      check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'h0);
      check("rst_inst_data", bus.inst_data, 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      int          p_redir, p_rdy, p_irdy, lat_min, lat_max, stall_left;
      bit          exp_rv, m_fire, resp, redir, pop, did_full_reset;
      logic [31:0] rpc;

      drive_idle();
      model_reset();
      stall_left     = 3;
      did_full_reset = 1'b0;
      #12;
      check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
      check("rst_inst_pc", bus.inst_pc, 32'h0);
      check("rst_inst_data", bus.inst_data, 32'h0);
      @(negedge clk);
      rst = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         if (cyc >= 300 && ((cyc % 450) == 0 || (!did_full_reset && m_fifo.size() == 2))) begin
            if (m_fifo.size() == 2) did_full_reset = 1'b1;
            apply_reset();
         end

         // Directed phases first (streaming, decode stall, memory stall, slow-memory redirect), then random.
         p_redir = 0; p_rdy = 100; p_irdy = 100; lat_min = 1; lat_max = 1;
         if (cyc >= 20 && cyc < 26) p_irdy = 0;
         else if (cyc >= 40 && cyc < 60) begin lat_min = 3; lat_max = 3; end
         else if (cyc >= 60) begin p_redir = 6; p_rdy = 70; p_irdy = 60; lat_min = 1; lat_max = 4; end

         bus.imem_req_ready = ($urandom_range(99) < p_rdy);
         if (cyc < 20 && m_pc == 32'h10 && stall_left > 0) begin
            bus.imem_req_ready = 1'b0;
            stall_left--;
         end
         bus.inst_ready     = ($urandom_range(99) < p_irdy);
         bus.redirect_valid = ($urandom_range(99) < p_redir) || (cyc == 50);
         case ($urandom_range(3))
            0:       rpc = 32'h0000_0200;
            1:       rpc = 32'hFFFF_FFF8;
            2:       rpc = $urandom;
            default: rpc = {$urandom_range(32'hFFFF), 14'h0, 2'($urandom_range(3))};
         endcase
         bus.redirect_pc = (cyc == 50) ? 32'h0000_0200 : rpc;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_q[0].addr ^ 32'hFFFF_FFFF;
         end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
         end
         #1;

         redir  = bus.redirect_valid;
         resp   = bus.imem_resp_valid;
         exp_rv = !redir && m_drop == 0 && (m_out + m_fifo.size() < 2);
         check("imem_req_valid", {31'b0, bus.imem_req_valid}, {31'b0, exp_rv});
         if (exp_rv) check("imem_req_addr", bus.imem_req_addr, m_pc);
         if (m_fifo.size() > 0) m_shown = m_fifo[0];
         check("inst_valid", {31'b0, bus.inst_valid}, {31'b0, m_fifo.size() > 0});
         check("inst_pc", bus.inst_pc, m_shown.pc);
         check("inst_data", bus.inst_data, m_shown.data);

         // Memory reacts to what the DUT actually does; the model advances by its own rules.
         if (bus.imem_req_valid && bus.imem_req_ready)
            mem_q.push_back('{addr: bus.imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
         if (resp) void'(mem_q.pop_front());

         m_fire = exp_rv && bus.imem_req_ready;
         pop    = m_fifo.size() > 0 && bus.inst_ready && !redir;
         if (redir) begin
            m_drop = m_out - (resp ? 1 : 0);
            m_fifo.delete();
            m_inflight.delete();
            m_pc = bus.redirect_pc;
         end else begin
            if (pop) void'(m_fifo.pop_front());
            if (resp) begin
               if (m_drop > 0) m_drop--;
               else if (m_inflight.size() == 0) check("resp_matches_request", 32'd0, 32'd1);
               else m_fifo.push_back('{pc: m_inflight.pop_front(), data: bus.imem_resp_data});
            end
            if (m_fire) begin
               m_inflight.push_back(m_pc);
               m_pc = m_pc + 32'd4;
            end
         end
         m_out = m_out + (m_fire ? 1 : 0) - (resp ? 1 : 0);

         @(negedge clk);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
